// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receive frame sequencer: start detect, bit timing, deserialize, parity/stop check
`timescale 1ns/1ps
module uart_rx_ctrl #(
    parameter int DATA_W  = 8,
    parameter int PRESC_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               RX_IN,
    input  logic [PRESC_W-1:0] prescale,
    input  logic               PAR_EN,
    input  logic               PAR_TYP,
    input  logic               sampled_bit,
    output logic [PRESC_W-1:0] edge_cnt,
    output logic [3:0]         bit_cnt,
    output logic               dat_samp_en,
    output logic [DATA_W-1:0]  P_DATA,
    output logic               data_valid,
    output logic               par_err,
    output logic               stp_err
);

    localparam int IDX_W = $clog2(DATA_W);
    localparam logic [PRESC_W-1:0] PRESC_ONE = {{(PRESC_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [PRESC_W-1:0] presc_q;
    logic [PRESC_W-1:0] presc_last;
    logic               par_en_q;
    logic               par_typ_q;
    logic [DATA_W-1:0]  shreg;
    logic [IDX_W-1:0]   bit_idx;
    logic               frame_par_bad;
    logic               bit_end;
    logic               start_det;
    logic               shift_en;
    logic               par_chk;
    logic               stop_chk;
    logic               par_mismatch;

    // An illegal prescale of 0 wraps presc_last to all-ones, so bit end is still reached
    always_comb begin
        presc_last   = presc_q - PRESC_ONE;
        bit_end      = (edge_cnt == presc_last);
        bit_idx      = IDX_W'(bit_cnt - 4'd1);
        par_mismatch = sampled_bit != ((^shreg) ^ par_typ_q);
        dat_samp_en  = (state != IDLE);
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and per-cycle datapath strobes, all decisions on bit end
    always_comb begin
        state_nxt = state;
        start_det = 1'b0;
        shift_en  = 1'b0;
        par_chk   = 1'b0;
        stop_chk  = 1'b0;
        case (state)
            IDLE: begin
                if (!RX_IN) begin
                    start_det = 1'b1;
                    state_nxt = START;
                end
            end
            START: begin
                if (bit_end) begin
                    state_nxt = sampled_bit ? IDLE : DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_en = 1'b1;
                    if (bit_cnt == 4'(DATA_W)) begin
                        state_nxt = par_en_q ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    par_chk   = 1'b1;
                    state_nxt = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    stop_chk = 1'b1;
                    if (!RX_IN) begin
                        start_det = 1'b1;
                        state_nxt = START;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Oversample and bit counters; both restart on start detection and rest at 0 in IDLE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (start_det || state_nxt == IDLE) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (bit_end) begin
            edge_cnt <= '0;
            bit_cnt  <= bit_cnt + 4'd1;
        end else begin
            edge_cnt <= edge_cnt + PRESC_ONE;
        end
    end

    // Frame configuration is frozen at start detection so mid-frame changes are ignored
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_q   <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
        end else if (start_det) begin
            presc_q   <= prescale;
            par_en_q  <= PAR_EN;
            par_typ_q <= PAR_TYP;
        end
    end

    // LSB-first deserializer: data bit n lands in shreg[n] when bit_cnt = n+1
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg <= '0;
        end else if (shift_en) begin
            shreg[bit_idx] <= sampled_bit;
        end
    end

    // Parity result of the frame in flight, kept apart from par_err so a back-to-back
    // frame is judged on its own parity rather than the previous frame's flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_par_bad <= 1'b0;
        end else if (start_det) begin
            frame_par_bad <= 1'b0;
        end else if (par_chk) begin
            frame_par_bad <= par_mismatch;
        end
    end

    // Error flags, byte output and one-cycle valid strobe
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            P_DATA     <= '0;
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            if (stop_chk) begin
                par_err <= frame_par_bad;
                stp_err <= ~sampled_bit;
                if (!frame_par_bad && sampled_bit) begin
                    P_DATA     <= shreg;
                    data_valid <= 1'b1;
                end
            end else if (par_chk) begin
                par_err <= par_mismatch;
            end else if (start_det) begin
                par_err <= 1'b0;
                stp_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - directed bench for uart_rx_ctrl
`timescale 1ns/1ps
module tb_uart_rx_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       RX_IN = 1'b1;
    logic [5:0] prescale = 6'd8;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic       sampled_bit = 1'b1;
    logic [5:0] edge_cnt;
    logic [3:0] bit_cnt;
    logic       dat_samp_en;
    logic [7:0] P_DATA;
    logic       data_valid;
    logic       par_err;
    logic       stp_err;

    int         total = 0;
    int         bad = 0;
    int         n_dv = 0;
    int         n0;
    logic [7:0] dv_data [0:63];
    time        dv_time [0:63];
    time        t_start;
    logic       found;

    uart_rx_ctrl #(.DATA_W(8), .PRESC_W(6)) dut (
        .clk         (clk),
        .rst         (rst),
        .RX_IN       (RX_IN),
        .prescale    (prescale),
        .PAR_EN      (PAR_EN),
        .PAR_TYP     (PAR_TYP),
        .sampled_bit (sampled_bit),
        .edge_cnt    (edge_cnt),
        .bit_cnt     (bit_cnt),
        .dat_samp_en (dat_samp_en),
        .P_DATA      (P_DATA),
        .data_valid  (data_valid),
        .par_err     (par_err),
        .stp_err     (stp_err)
    );

    always #5 clk = ~clk;

    // Simple sampler model: captures the line mid-bit, stable well before bit end
    always @(posedge clk) begin
        if (edge_cnt == (prescale >> 1)) sampled_bit <= RX_IN;
    end

    // Strobe monitor, sampled away from the active edge
    always @(negedge clk) begin
        if (data_valid) begin
            if (n_dv < 64) begin
                dv_data[n_dv] = P_DATA;
                dv_time[n_dv] = $time;
            end
            n_dv++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called on a negedge; returns on the negedge just before the stop-bit bit end
    task automatic send_frame(input logic [7:0] d, input logic pbit, input logic sbit);
        RX_IN   = 1'b0;
        t_start = $time + 5;
        repeat (prescale) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RX_IN = d[i];
            repeat (prescale) @(negedge clk);
        end
        if (PAR_EN) begin
            RX_IN = pbit;
            repeat (prescale) @(negedge clk);
        end
        RX_IN = sbit;
        repeat (prescale) @(negedge clk);
    endtask

    task automatic idle(input int n);
        RX_IN = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        // reset state
        @(negedge clk);
        check("reset_out", {10'd0, edge_cnt, bit_cnt, dat_samp_en, P_DATA, data_valid, par_err, stp_err}, 32'd0);
        rst = 1'b1;
        idle(4);

        // prescale 8, no parity, 0xA5
        prescale = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0;
        n0 = n_dv;
        send_frame(8'hA5, 1'b0, 1'b1);
        idle(3);
        check("a5_strobes", n_dv - n0, 1);
        check("a5_data", dv_data[n0], 8'hA5);
        check("a5_latency", 32'((dv_time[n0] - t_start - 5) / 10), 80);
        check("a5_flags", {par_err, stp_err}, 2'b00);

        // prescale 16, even parity, good then bad parity bit
        prescale = 6'd16; PAR_EN = 1'b1; PAR_TYP = 1'b0;
        n0 = n_dv;
        send_frame(8'h3C, 1'b0, 1'b1);
        idle(3);
        check("3c_strobes", n_dv - n0, 1);
        check("3c_data", P_DATA, 8'h3C);
        check("3c_latency", 32'((dv_time[n0] - t_start - 5) / 10), 176);
        check("3c_par_err", par_err, 1'b0);
        n0 = n_dv;
        send_frame(8'h3C, 1'b1, 1'b1);
        idle(3);
        check("3c_bad_strobes", n_dv - n0, 0);
        check("3c_bad_flags", {par_err, stp_err}, 2'b10);
        check("3c_bad_hold", P_DATA, 8'h3C);

        // prescale 32, odd parity, stop bit 0 then a good frame
        prescale = 6'd32; PAR_EN = 1'b1; PAR_TYP = 1'b1;
        n0 = n_dv;
        send_frame(8'h01, 1'b0, 1'b0);
        idle(3);
        check("01_strobes", n_dv - n0, 0);
        check("01_flags", {par_err, stp_err}, 2'b01);
        check("01_hold", P_DATA, 8'h3C);
        n0 = n_dv;
        send_frame(8'h7E, 1'b1, 1'b1);
        idle(3);
        check("7e_strobes", n_dv - n0, 1);
        check("7e_data", P_DATA, 8'h7E);
        check("7e_flags", {par_err, stp_err}, 2'b00);

        // start glitch at prescale 8
        prescale = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0;
        n0 = n_dv;
        RX_IN = 1'b0;
        repeat (2) @(negedge clk);
        RX_IN = 1'b1;
        repeat (6) @(negedge clk);
        check("glitch_edge7", {edge_cnt, dat_samp_en}, {6'd7, 1'b1});
        @(negedge clk);
        check("glitch_idle", {edge_cnt, bit_cnt, dat_samp_en}, 11'd0);
        idle(3);
        check("glitch_strobes", n_dv - n0, 0);
        check("glitch_flags", {par_err, stp_err}, 2'b00);

        // back-to-back frames
        n0 = n_dv;
        send_frame(8'h55, 1'b0, 1'b1);
        send_frame(8'hAA, 1'b0, 1'b1);
        idle(3);
        check("b2b_strobes", n_dv - n0, 2);
        check("b2b_first", dv_data[n0], 8'h55);
        check("b2b_second", dv_data[n0 + 1], 8'hAA);
        check("b2b_spacing", 32'((dv_time[n0 + 1] - dv_time[n0]) / 10), 80);

        // reset mid-frame at bit_cnt 4
        n0 = n_dv;
        RX_IN = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            RX_IN = (bit_cnt == 4'd0) ? 1'b0 : 1'b1;
            if (bit_cnt == 4'd4) found = 1'b1;
        end
        check("reach_bit4", found, 1'b1);
        #2 rst = 1'b0;
        #1 check("midreset_out", {10'd0, edge_cnt, bit_cnt, dat_samp_en, P_DATA, data_valid, par_err, stp_err}, 32'd0);
        @(negedge clk);
        RX_IN = 1'b1;
        rst = 1'b1;
        idle(4);
        send_frame(8'hC3, 1'b0, 1'b1);
        idle(3);
        check("c3_strobes", n_dv - n0, 1);
        check("c3_data", P_DATA, 8'hC3);
        check("c3_flags", {par_err, stp_err}, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
